// File: rtl/byte_bus_ctrl.sv
// Byte-serial bus controller: arbitrates the fetch and load/store ports onto an 8-bit RAM/UART
// bus, splitting 1/2/4-byte accesses into little-endian beats with one-cycle read latency.
module byte_bus_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_done,
  input  logic        data_r_req,
  input  logic        data_w_req,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_w_data,
  output logic [31:0] data_r_data,
  output logic        data_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        from_inst;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] acc;
  logic [31:0] inst_hold;
  logic [31:0] data_hold;
  logic [31:0] mem_a_q;
  logic [7:0]  dout_q;
  logic [1:0]  last;
  logic [1:0]  beat;
  logic [1:0]  cap;
  logic        addr_valid;
  logic        din_valid;

  logic [1:0]  req_last;
  logic [1:0]  next_beat;
  logic [31:0] word;
  logic        abort;
  logic        stall;
  logic        rd_fin;
  logic        wr_fin;

  assign req_last  = (data_size == 2'd2) ? 2'd3 : data_size;
  assign next_beat = beat + 2'd1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    word = acc;
    word[{cap, 3'b000} +: 8] = mem_din;
  end

  assign abort  = (state == READ) && from_inst && !inst_req;
  assign stall  = (base[17:16] == IO_SEL) && io_buffer_full;
  assign rd_fin = (state == READ) && din_valid && (cap == last) && !abort;
  assign wr_fin = (state == WRITE) && !stall && (beat == last);

  // The last byte is merged straight from mem_din so the done pulse lands in the capture cycle.
  assign inst_done   = rdy && rd_fin && from_inst;
  assign data_done   = rdy && ((rd_fin && !from_inst) || wr_fin);
  assign inst_data   = inst_done ? word : inst_hold;
  assign data_r_data = (rdy && rd_fin && !from_inst) ? word : data_hold;
  assign mem_wr      = rdy && (state == WRITE) && !stall;
  assign mem_a       = mem_a_q;
  assign mem_dout    = dout_q;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, sampled at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      from_inst  <= 1'b0;
      base       <= '0;
      wdata      <= '0;
      acc        <= '0;
      inst_hold  <= '0;
      data_hold  <= '0;
      mem_a_q    <= '0;
      dout_q     <= '0;
      last       <= '0;
      beat       <= '0;
      cap        <= '0;
      addr_valid <= 1'b0;
      din_valid  <= 1'b0;
    end else if (!rdy) begin
      // A frozen read loses the byte in flight: rewind the issue pointer to the first uncaptured byte.
      if (state == READ) begin
        din_valid  <= 1'b0;
        addr_valid <= 1'b1;
        beat       <= cap;
        mem_a_q    <= base + {30'd0, cap};
      end
    end else begin
      case (state)
        IDLE: begin
          if (data_w_req) begin
            state     <= WRITE;
            from_inst <= 1'b0;
            base      <= data_addr;
            last      <= req_last;
            wdata     <= data_w_data;
            beat      <= 2'd0;
            mem_a_q   <= data_addr;
            dout_q    <= data_w_data[7:0];
          end else if (data_r_req || inst_req) begin
            state      <= READ;
            from_inst  <= !data_r_req;
            base       <= data_r_req ? data_addr : inst_addr;
            mem_a_q    <= data_r_req ? data_addr : inst_addr;
            last       <= data_r_req ? req_last : 2'd3;
            beat       <= 2'd0;
            cap        <= 2'd0;
            acc        <= '0;
            addr_valid <= 1'b1;
            din_valid  <= 1'b0;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            din_valid <= addr_valid;
            if (addr_valid) begin
              if (beat == last) begin
                addr_valid <= 1'b0;
              end else begin
                beat    <= next_beat;
                mem_a_q <= base + {30'd0, next_beat};
              end
            end
            if (din_valid) begin
              acc <= word;
              cap <= cap + 2'd1;
            end
            if (rd_fin) begin
              state <= DONE;
              if (from_inst) inst_hold <= word;
              else           data_hold <= word;
            end
          end
        end
        WRITE: begin
          if (!stall) begin
            if (beat == last) begin
              state <= DONE;
            end else begin
              beat    <= next_beat;
              mem_a_q <= base + {30'd0, next_beat};
              dout_q  <= wdata[{next_beat, 3'b000} +: 8];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
